hazard_scoreboard: RTL and testbench

- Parametrised successor to the fixed 5-stage hazard logic; replaces distance-based RdE/RdM/RdW compares with a per-register scoreboard.
- Supports variable-latency execution units (e.g. multi-cycle MDU, load with wait states) through per-register countdown counters.
- Sits beside the ID stage. Issue occurs at ID->EX handoff; writeback retires at WB.
- Produces the ID-stage stall and per-source bypass-ready indications.

---
 rtl/hazard_scoreboard_pkg.sv | 34 +++
 rtl/hazard_scoreboard_sb_entry.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default widths for the per-register hazard scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_scoreboard_pkg;

  // Default widths; the top module parameters take these as defaults.
  localparam int SB_LAT_W = 4;
  localparam int SB_TAG_W = 3;

  typedef logic [SB_TAG_W-1:0] sb_tag_t;
  typedef logic [SB_LAT_W-1:0] sb_lat_t;

  // State held for one architectural register.
  typedef struct packed {
    logic    busy;
    sb_lat_t cnt;
    sb_tag_t tag;
  } sb_entry_t;

  // Issue and writeback bundles as seen by the scoreboard.
  typedef struct packed {
    logic    valid;
    logic    regwrite;
    logic [4:0] rd;
    sb_lat_t lat;
  } sb_issue_t;

  typedef struct packed {
    logic    valid;
    logic [4:0] rd;
    sb_tag_t tag;
  } sb_wb_t;

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's scoreboard slot: allocate, countdown to bypassable, retire on tag match.
// Latency: state updates on the clock edge following alloc/retire.
// Backpressure: none; the top only raises alloc for accepted issues.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = SB_LAT_W,
  parameter int TAG_W = SB_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [LAT_W-1:0] lat,
  input  logic [TAG_W-1:0] new_tag,
  input  logic             retire,
  input  logic [TAG_W-1:0] retire_tag,
  output logic             busy,
  output logic [LAT_W-1:0] cnt,
  output logic [TAG_W-1:0] tag
);

  logic tag_hit;

  // A writeback only frees the slot when it comes from the youngest writer.
  assign tag_hit = retire && busy && (tag == retire_tag);

  // Allocation beats retirement; otherwise the countdown runs and saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      tag  <= '0;
    end else if (alloc) begin
      busy <= 1'b1;
      cnt  <= lat;
      tag  <= new_tag;
    end else if (tag_hit) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy && (cnt != '0)) begin
      cnt  <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stall and bypass-ready per source from per-register countdowns.
// Latency: stall/bypass/tag outputs are combinational on current state; state moves on the edge.
// Backpressure: stall_o holds ID/IF on RAW, WAW-reorder, or in-flight limit; issue not accepted.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS        = 32,
  parameter int LAT_W        = SB_LAT_W,
  parameter int TAG_W        = SB_TAG_W,
  parameter int MAX_INFLIGHT = 6,
  parameter int RW           = $clog2(NREGS),
  parameter int IW           = $clog2(MAX_INFLIGHT+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid_i,
  input  logic             issue_regwrite_i,
  input  logic [RW-1:0]    issue_rd_i,
  input  logic [LAT_W-1:0] issue_lat_i,
  input  logic [RW-1:0]    rs1_i,
  input  logic [RW-1:0]    rs2_i,
  input  logic             rs1_used_i,
  input  logic             rs2_used_i,
  input  logic             wb_valid_i,
  input  logic [RW-1:0]    wb_rd_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  output logic             stall_o,
  output logic [TAG_W-1:0] issue_tag_o,
  output logic             rs1_byp_o,
  output logic             rs2_byp_o,
  output logic [IW-1:0]    inflight_o
);

  logic [NREGS-1:0] busy;
  logic [LAT_W-1:0] cnt [NREGS];
  logic [TAG_W-1:0] tag [NREGS];

  logic [TAG_W-1:0] next_tag;
  logic [IW-1:0]    inflight;

  logic alloc_req, alloc;
  logic clr1, clr2;
  logic haz1, haz2, waw, full;

  // x0 is hardwired: never busy, never counts, never holds a tag.
  assign busy[0] = 1'b0;
  assign cnt[0]  = '0;
  assign tag[0]  = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    sb_entry #(
      .LAT_W (LAT_W),
      .TAG_W (TAG_W)
    ) u_entry (
      .clk        (clk),
      .reset      (reset),
      .alloc      (alloc && (issue_rd_i == RW'(r))),
      .lat        (issue_lat_i),
      .new_tag    (next_tag),
      .retire     (wb_valid_i && (wb_rd_i == RW'(r))),
      .retire_tag (wb_tag_i),
      .busy       (busy[r]),
      .cnt        (cnt[r]),
      .tag        (tag[r])
    );
  end

  // Source hazard, WAW ordering and capacity checks feeding the single stall.
  always_comb begin
    alloc_req = issue_valid_i && issue_regwrite_i && (issue_rd_i != '0);

    // Regfile writes through on a matching retire, so the source is simply ready.
    clr1 = wb_valid_i && (wb_rd_i == rs1_i) && busy[rs1_i] && (tag[rs1_i] == wb_tag_i);
    clr2 = wb_valid_i && (wb_rd_i == rs2_i) && busy[rs2_i] && (tag[rs2_i] == wb_tag_i);

    haz1 = rs1_used_i && (rs1_i != '0) && busy[rs1_i] && (cnt[rs1_i] != '0) && !clr1;
    haz2 = rs2_used_i && (rs2_i != '0) && busy[rs2_i] && (cnt[rs2_i] != '0) && !clr2;

    // A younger writer must not become visible before an older one to the same rd.
    waw  = alloc_req && busy[issue_rd_i] && (issue_lat_i < cnt[issue_rd_i]);
    full = alloc_req && (inflight == IW'(MAX_INFLIGHT)) && !wb_valid_i;

    stall_o   = issue_valid_i && (haz1 || haz2 || waw || full);
    alloc     = alloc_req && !stall_o;

    rs1_byp_o = busy[rs1_i] && (cnt[rs1_i] == '0) && !clr1;
    rs2_byp_o = busy[rs2_i] && (cnt[rs2_i] == '0) && !clr2;
  end

  assign issue_tag_o = next_tag;
  assign inflight_o  = inflight;

  // Tag counter advances only on accepted allocations; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_tag <= '0;
    end else if (alloc) begin
      next_tag <= next_tag + 1'b1;
    end
  end

  // Every writeback pulse belongs to some allocated writer, matching tag or not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      inflight <= inflight + IW'(alloc) - IW'(wb_valid_i);
    end
  end

  // A writeback with nothing in flight (and nothing arriving) means lost bookkeeping.
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(wb_valid_i && (inflight == '0) && !alloc));

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  typedef struct {
    logic       iv;
    logic       rw;
    logic [4:0] rd;
    logic [3:0] lat;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       wv;
    logic [4:0] wrd;
    logic [2:0] wtg;
    logic       e_stall;
    logic [2:0] e_tag;
    logic       e_b1;
    logic       e_b2;
    logic [2:0] e_inf;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       issue_valid_i, issue_regwrite_i;
  logic [4:0] issue_rd_i;
  logic [3:0] issue_lat_i;
  logic [4:0] rs1_i, rs2_i;
  logic       rs1_used_i, rs2_used_i;
  logic       wb_valid_i;
  logic [4:0] wb_rd_i;
  logic [2:0] wb_tag_i;
  logic       stall_o;
  logic [2:0] issue_tag_o;
  logic       rs1_byp_o, rs2_byp_o;
  logic [2:0] inflight_o;

  int errors = 0;
  int checks = 0;

  vec_t tbl[$];
  vec_t exp_q[$];

  hazard_scoreboard dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid_i    (issue_valid_i),
    .issue_regwrite_i (issue_regwrite_i),
    .issue_rd_i       (issue_rd_i),
    .issue_lat_i      (issue_lat_i),
    .rs1_i            (rs1_i),
    .rs2_i            (rs2_i),
    .rs1_used_i       (rs1_used_i),
    .rs2_used_i       (rs2_used_i),
    .wb_valid_i       (wb_valid_i),
    .wb_rd_i          (wb_rd_i),
    .wb_tag_i         (wb_tag_i),
    .stall_o          (stall_o),
    .issue_tag_o      (issue_tag_o),
    .rs1_byp_o        (rs1_byp_o),
    .rs2_byp_o        (rs2_byp_o),
    .inflight_o       (inflight_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(
    input logic iv, input logic rw, input int rd, input int lat,
    input int rs1, input logic u1, input int rs2, input logic u2,
    input logic wv, input int wrd, input int wtg,
    input logic st, input int tg, input logic b1, input logic b2, input int inf);
    vec_t v;
    v.iv = iv; v.rw = rw; v.rd = 5'(rd); v.lat = 4'(lat);
    v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
    v.wv = wv; v.wrd = 5'(wrd); v.wtg = 3'(wtg);
    v.e_stall = st; v.e_tag = 3'(tg); v.e_b1 = b1; v.e_b2 = b2; v.e_inf = 3'(inf);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issue_valid_i    = v.iv;
    issue_regwrite_i = v.rw;
    issue_rd_i       = v.rd;
    issue_lat_i      = v.lat;
    rs1_i            = v.rs1;
    rs1_used_i       = v.u1;
    rs2_i            = v.rs2;
    rs2_used_i       = v.u2;
    wb_valid_i       = v.wv;
    wb_rd_i          = v.wrd;
    wb_tag_i         = v.wtg;
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  task automatic chk(input vec_t e, input string nm);
    cmp(nm, "stall",    int'(stall_o),     int'(e.e_stall));
    cmp(nm, "tag",      int'(issue_tag_o), int'(e.e_tag));
    cmp(nm, "byp1",     int'(rs1_byp_o),   int'(e.e_b1));
    cmp(nm, "byp2",     int'(rs2_byp_o),   int'(e.e_b2));
    cmp(nm, "inflight", int'(inflight_o),  int'(e.e_inf));
  endtask

  // Drive just after the edge, compare on the falling edge before the next commit.
  task automatic apply(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(v);
    exp_q.push_back(v);
    @(negedge clk);
    chk(exp_q.pop_front(), nm);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    drive(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int t;
    vec_t idle;

    reset = 1'b1;
    idle  = mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0);
    drive(idle);
    #3;
    chk(idle, "reset_state");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // RAW load-use: x5 lat=1, dependent stalls one cycle then bypasses.
    tbl.push_back(mk(1,1,5,1, 0,0,0,0, 0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0, 5,1,0,0, 0,0,0, 1,1,0,0,1));
    tbl.push_back(mk(1,0,0,0, 5,1,0,0, 0,0,0, 0,1,1,0,1));
    tbl.push_back(mk(0,0,0,0, 5,1,0,0, 1,5,0, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0, 5,1,0,0, 0,0,0, 0,1,0,0,0));
    // Multi-cycle x7 lat=5: five stall cycles, then bypass, then retire.
    tbl.push_back(mk(1,1,7,5, 0,0,0,0, 0,0,0, 0,1,0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1,0,0,0, 0,0,7,1, 0,0,0, 1,2,0,0,1));
    tbl.push_back(mk(1,0,0,0, 0,0,7,1, 0,0,0, 0,2,0,1,1));
    tbl.push_back(mk(0,0,0,0, 0,0,7,1, 1,7,1, 0,2,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,7,1, 0,0,0, 0,2,0,0,0));
    // WAW: x3 lat=6 (tag2) then x3 lat=2 waits until cnt<=2; old-tag wb ignored.
    tbl.push_back(mk(1,1,3,6, 0,0,0,0, 0,0,0, 0,2,0,0,0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1,1,3,2, 0,0,0,0, 0,0,0, 1,3,0,0,1));
    tbl.push_back(mk(1,1,3,2, 0,0,0,0, 0,0,0, 0,3,0,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,3,2, 0,4,0,0,2));
    tbl.push_back(mk(1,0,0,0, 3,1,0,0, 0,0,0, 1,4,0,0,1));
    tbl.push_back(mk(1,0,0,0, 3,1,0,0, 0,0,0, 0,4,1,0,1));
    tbl.push_back(mk(1,0,0,0, 3,1,0,0, 1,3,3, 0,4,0,0,1));
    tbl.push_back(mk(1,0,0,0, 3,1,0,0, 0,0,0, 0,4,0,0,0));
    // Full: six writers x10..x15, seventh stalls, accepted alongside a wb.
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(1,1,10+i,3, 0,0,0,0, 0,0,0, 0,(4+i)%8,0,0,i));
    tbl.push_back(mk(1,1,16,3, 0,0,0,0, 0,0,0, 1,2,0,0,6));
    tbl.push_back(mk(1,1,16,3, 0,0,0,0, 1,10,4, 0,2,0,0,6));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 1,11+i,(5+i)%8, 0,3,0,0,6-i));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,3,0,0,0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Tag wrap: 20 issue/bypass/retire triples from a clean reset.
    do_reset();
    t = 0;
    for (int i = 0; i < 20; i++) begin
      apply(mk(1,1,9,0, 0,0,0,0, 0,0,0,  0,t,0,0,0),          $sformatf("wrap%0d_iss", i));
      apply(mk(0,0,0,0, 9,1,0,0, 0,0,0,  0,(t+1)%8,1,0,1),    $sformatf("wrap%0d_byp", i));
      apply(mk(0,0,0,0, 9,1,0,0, 1,9,t,  0,(t+1)%8,0,0,1),    $sformatf("wrap%0d_wb", i));
      t = (t + 1) % 8;
    end
    apply(mk(0,0,0,0, 9,1,0,0, 0,0,0, 0,t,0,0,0), "wrap_end");

    // x0 destination and non-writing issue never allocate nor advance the tag.
    apply(mk(1,1,0,3, 0,0,0,0, 0,0,0, 0,t,0,0,0), "x0_iss");
    apply(mk(1,0,0,0, 0,1,0,1, 0,0,0, 0,t,0,0,0), "x0_read");
    apply(mk(1,0,5,2, 0,0,0,0, 0,0,0, 0,t,0,0,0), "norw_iss");
    apply(mk(1,0,0,0, 5,1,0,0, 0,0,0, 0,t,0,0,0), "norw_read");

    // Asynchronous reset in the middle of a stall.
    apply(mk(1,1,20,9, 0,0,0,0, 0,0,0, 0,t,0,0,0), "rst_iss");
    apply(mk(1,0,0,0, 20,1,0,0, 0,0,0, 1,(t+1)%8,0,0,1), "rst_stall");
    @(posedge clk);
    #1;
    drive(mk(1,0,0,0, 20,1,0,0, 0,0,0, 0,0,0,0,0));
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(1,0,0,0, 20,1,0,0, 0,0,0, 0,0,0,0,0));
    chk(exp_q.pop_front(), "rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(mk(1,0,0,0, 20,1,0,0, 0,0,0, 0,0,0,0,0), "rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
